vgg_frame_scheduler: RTL and testbench

- Sequences whole image frames from the input FIFO into the `vgg16_lite_2` accelerator.
- Reads exactly WIDTH×HEIGHT words per frame, issuing reads only when the input FIFO is non-empty and the output FIFO is not full.
- Waits for the accelerator's `done` before starting the next frame, counts frames against a programmed total, and flags protocol errors.
- Sits between the FIFO pair and the accelerator inside the core wrapper, replacing the free-running read/valid logic.

---
 rtl/vgg_ctrl_pkg.sv | 22 ++
 rtl/vgg_frame_scheduler_if.sv | 26 ++
 rtl/vgg_frame_scheduler.sv | 134 +++++++++++++
 tb/tb_vgg_frame_scheduler.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vgg_ctrl_pkg.sv
// Shared control definitions for the VGG layer/frame schedulers:
// state encoding plus frame-size and counter-width helpers.
package vgg_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_STREAM    = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_FINISH    = 2'd3
    } sched_state_e;

    // Number of pixel words in one frame.
    function automatic int frame_pix(input int w, input int h);
        return w * h;
    endfunction

    // Width of a counter spanning 0..pix-1; never narrower than one bit.
    function automatic int pix_cnt_w(input int pix);
        return (pix > 1) ? $clog2(pix) : 1;
    endfunction

endpackage

// File: rtl/vgg_frame_scheduler_if.sv
// FIFO-pair / accelerator handshake bundle seen by the frame scheduler.
// master: the scheduler (issues reads, drives valid_in into the core).
// slave : the FIFOs and accelerator surrounding it.
interface vgg_frame_scheduler_if;
    logic ff_empty;
    logic ff_full;
    logic ff_rdreq;
    logic core_valid_in;
    logic core_done;

    modport master (
        input  ff_empty,
        input  ff_full,
        input  core_done,
        output ff_rdreq,
        output core_valid_in
    );

    modport slave (
        output ff_empty,
        output ff_full,
        output core_done,
        input  ff_rdreq,
        input  core_valid_in
    );
endinterface

// File: rtl/vgg_frame_scheduler.sv
// Frame scheduler: streams WIDTH*HEIGHT words per frame from the input
// FIFO into the accelerator, waits for its done pulse between frames,
// counts frames against the programmed total and flags stray done pulses.
module vgg_frame_scheduler
    import vgg_ctrl_pkg::*;
#(
    parameter int WIDTH  = 56,
    parameter int HEIGHT = 56,
    parameter int FRM_W  = 16
) (
    input  logic                 clk,
    input  logic                 resetn,      // active-high synchronous reset
    input  logic                 start,
    input  logic                 abort,
    input  logic [FRM_W-1:0]     num_frames,
    vgg_frame_scheduler_if.master bus,
    output logic                 busy,
    output logic [FRM_W-1:0]     frame_idx,
    output logic                 frame_done,
    output logic                 job_done,
    output logic                 err
);

    localparam int FRAME_PIX = frame_pix(WIDTH, HEIGHT);
    localparam int PIX_W     = pix_cnt_w(FRAME_PIX);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(FRAME_PIX - 1);

    sched_state_e     state_q, state_d;
    logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [FRM_W-1:0] frame_idx_q, frame_idx_d;
    logic [FRM_W-1:0] num_frames_q, num_frames_d;
    logic             err_q, err_d;
    logic             frame_done_q, frame_done_d;
    logic             job_done_q, job_done_d;
    logic             valid_q;
    logic             rdreq;

    // Next-state, counters, pulse requests and the combinational read request.
    always_comb begin
        state_d      = state_q;
        pix_cnt_d    = pix_cnt_q;
        frame_idx_d  = frame_idx_q;
        num_frames_d = num_frames_q;
        err_d        = err_q;
        frame_done_d = 1'b0;
        job_done_d   = 1'b0;
        rdreq        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (num_frames != '0) begin
                        num_frames_d = num_frames;
                        frame_idx_d  = '0;
                        pix_cnt_d    = '0;
                        err_d        = 1'b0;
                        state_d      = ST_STREAM;
                    end else begin
                        job_done_d = 1'b1;
                    end
                end
            end
            ST_STREAM: begin
                // abort drops the request in the same cycle it arrives
                rdreq = !bus.ff_empty && !bus.ff_full && !abort;
                if (rdreq) begin
                    if (pix_cnt_q == PIX_LAST) begin
                        pix_cnt_d = '0;
                        state_d   = ST_WAIT_DONE;
                    end else begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (bus.core_done && !abort) begin
                    frame_done_d = 1'b1;
                    if (frame_idx_q == num_frames_q - 1'b1) begin
                        state_d = ST_FINISH;
                    end else begin
                        frame_idx_d = frame_idx_q + 1'b1;
                        state_d     = ST_STREAM;
                    end
                end
            end
            ST_FINISH: begin
                job_done_d = !abort;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A done pulse while nothing is pending in the core is a protocol error.
        if (bus.core_done && (state_q == ST_IDLE || state_q == ST_STREAM)) begin
            err_d = 1'b1;
        end

        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
        end
    end

    // State and output registers; valid_in trails rdreq by the FIFO read latency.
    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q      <= ST_IDLE;
            pix_cnt_q    <= '0;
            frame_idx_q  <= '0;
            num_frames_q <= '0;
            err_q        <= 1'b0;
            frame_done_q <= 1'b0;
            job_done_q   <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_cnt_q    <= pix_cnt_d;
            frame_idx_q  <= frame_idx_d;
            num_frames_q <= num_frames_d;
            err_q        <= err_d;
            frame_done_q <= frame_done_d;
            job_done_q   <= job_done_d;
            valid_q      <= rdreq;
        end
    end

    assign bus.ff_rdreq      = rdreq;
    assign bus.core_valid_in = valid_q;
    assign busy              = (state_q != ST_IDLE);
    assign frame_idx         = frame_idx_q;
    assign frame_done        = frame_done_q;
    assign job_done          = job_done_q;
    assign err               = err_q;

endmodule

// File: tb/tb_vgg_frame_scheduler.sv
// Self-checking bench for vgg_frame_scheduler with WIDTH=4, HEIGHT=2.
// Expected per-frame read counts are queued at job start and matched
// against the reads observed between frame_done pulses.
module tb_vgg_frame_scheduler;

    localparam int W = 4;
    localparam int H = 2;
    localparam int FRAME_PIX = 8;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] num_frames = '0;
    logic        busy, frame_done, job_done, err;
    logic [15:0] frame_idx;

    vgg_frame_scheduler_if bus_if ();

    vgg_frame_scheduler #(.WIDTH(W), .HEIGHT(H), .FRM_W(16)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .abort      (abort),
        .num_frames (num_frames),
        .bus        (bus_if),
        .busy       (busy),
        .frame_idx  (frame_idx),
        .frame_done (frame_done),
        .job_done   (job_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // observation / accelerator-model state
    int cyc = 0, reads = 0, frame_reads = 0, fd_cnt = 0, jd_cnt = 0;
    int fd_cyc = 0, jd_cyc = 0, busy_cnt = 0, st_bad = 0, vd_bad = 0;
    int acc_cnt = 0, acc_delay = 0;
    bit acc_en = 1'b1;
    bit prev_rdreq = 1'b0;
    int exp_q[$];
    int got_q[$];

    // One clock: drive inputs on the falling edge, sample 1 ns later.
    task automatic step(input bit bp, input bit st, input logic [15:0] nf,
                        input bit ab, input bit rst, input bit cdf);
        bit cd;
        @(negedge clk);
        bus_if.ff_empty = bp ? ($urandom_range(0, 2) == 0) : 1'b0;
        bus_if.ff_full  = bp ? ($urandom_range(0, 3) == 0) : 1'b0;
        start      = st;
        num_frames = nf;
        abort      = ab;
        resetn     = rst;
        cd = cdf;
        if (acc_delay > 0) begin
            acc_delay--;
            if (acc_delay == 0) cd = 1'b1;
        end
        bus_if.core_done = cd;
        #1;
        cyc++;
        if (frame_done) begin
            got_q.push_back(frame_reads);
            frame_reads = 0;
            fd_cnt++;
            fd_cyc = cyc;
        end
        if (job_done) begin
            jd_cnt++;
            jd_cyc = cyc;
        end
        if (busy) busy_cnt++;
        if (bus_if.ff_rdreq) begin
            frame_reads++;
            reads++;
            if (bus_if.ff_empty || bus_if.ff_full) st_bad++;
        end
        if (bus_if.core_valid_in !== prev_rdreq) vd_bad++;
        prev_rdreq = rst ? 1'b0 : bus_if.ff_rdreq;
        if (bus_if.core_valid_in && acc_en) begin
            acc_cnt++;
            if (acc_cnt == FRAME_PIX) begin
                acc_cnt   = 0;
                acc_delay = 2;
            end
        end
    endtask

    task automatic tick();
        step(1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic begin_job(input int nf, input bit bp);
        reads = 0; frame_reads = 0; fd_cnt = 0; jd_cnt = 0; busy_cnt = 0;
        st_bad = 0; vd_bad = 0; acc_cnt = 0; acc_delay = 0;
        exp_q.delete();
        got_q.delete();
        for (int i = 0; i < nf; i++) exp_q.push_back(FRAME_PIX);
        step(bp, 1'b1, 16'(nf), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_until_jd(input bit bp, input int budget);
        for (int i = 0; i < budget && jd_cnt == 0; i++)
            step(bp, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
        tick();
        n_cmp++;
        if ({bus_if.ff_rdreq, bus_if.core_valid_in, busy, frame_done, job_done, err} !== 6'b0
            || frame_idx !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: rdreq=%b valid=%b busy=%b fd=%b jd=%b err=%b idx=%0d, all must be 0",
                     bus_if.ff_rdreq, bus_if.core_valid_in, busy, frame_done, job_done, err, frame_idx);
        end
    endtask

    task automatic test_nominal();
        int e, g;
        begin_job(2, 1'b0);
        tick();
        n_cmp++;
        if (busy !== 1'b1 || bus_if.ff_rdreq !== 1'b1) begin
            n_bad++;
            $display("FAIL nom_first_cycle: busy=%b rdreq=%b, required 1/1", busy, bus_if.ff_rdreq);
        end
        for (int i = 0; i < 7; i++) tick();
        n_cmp++;
        if (frame_reads !== 8) begin
            n_bad++;
            $display("FAIL nom_consecutive_reads: got %0d in 8 cycles, required 8", frame_reads);
        end
        tick();
        n_cmp++;
        if (bus_if.ff_rdreq !== 1'b0) begin
            n_bad++;
            $display("FAIL nom_ninth_read: rdreq=%b, required 0", bus_if.ff_rdreq);
        end
        run_until_jd(1'b0, 200);
        n_cmp++;
        if (jd_cnt != 1) begin n_bad++; $display("FAIL nom_job_done: count %0d, required 1", jd_cnt); end
        n_cmp++;
        if (reads != 16) begin n_bad++; $display("FAIL nom_total_reads: %0d, required 16", reads); end
        n_cmp++;
        if (fd_cnt != 2) begin n_bad++; $display("FAIL nom_frame_done: count %0d, required 2", fd_cnt); end
        n_cmp++;
        if (jd_cyc != fd_cyc + 1) begin
            n_bad++;
            $display("FAIL nom_jd_timing: job_done cycle %0d, required %0d", jd_cyc, fd_cyc + 1);
        end
        n_cmp++;
        if (vd_bad != 0) begin n_bad++; $display("FAIL nom_valid_delay: %0d bad cycles, required 0", vd_bad); end
        n_cmp++;
        if (frame_idx !== 16'd1) begin n_bad++; $display("FAIL nom_frame_idx: %0d, required 1", frame_idx); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (got_q.size() == 0) begin
                n_bad++; $display("FAIL nom_sb_missing: no frame observed, required %0d reads", e);
            end else begin
                g = got_q.pop_front();
                if (g != e) begin n_bad++; $display("FAIL nom_sb_reads: %0d, required %0d", g, e); end
            end
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL nom_idle_after: busy=%b, required 0", busy); end
    endtask

    task automatic test_backpressure();
        int e, g;
        begin_job(3, 1'b1);
        run_until_jd(1'b1, 3000);
        n_cmp++;
        if (jd_cnt != 1) begin n_bad++; $display("FAIL bp_job_done: count %0d, required 1", jd_cnt); end
        n_cmp++;
        if (st_bad != 0) begin n_bad++; $display("FAIL bp_read_while_stalled: %0d cycles, required 0", st_bad); end
        n_cmp++;
        if (reads != 24) begin n_bad++; $display("FAIL bp_total_reads: %0d, required 24", reads); end
        n_cmp++;
        if (vd_bad != 0) begin n_bad++; $display("FAIL bp_valid_delay: %0d bad cycles, required 0", vd_bad); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (got_q.size() == 0) begin
                n_bad++; $display("FAIL bp_sb_missing: no frame observed, required %0d reads", e);
            end else begin
                g = got_q.pop_front();
                if (g != e) begin n_bad++; $display("FAIL bp_sb_reads: %0d, required %0d", g, e); end
            end
        end
    endtask

    task automatic test_zero_frames();
        begin_job(0, 1'b0);
        tick();
        n_cmp++;
        if (job_done !== 1'b1) begin n_bad++; $display("FAIL zero_jd_next_cycle: job_done=%b, required 1", job_done); end
        for (int i = 0; i < 3; i++) tick();
        n_cmp++;
        if (jd_cnt != 1 || busy_cnt != 0 || reads != 0) begin
            n_bad++;
            $display("FAIL zero_frames: jd=%0d busy_cycles=%0d reads=%0d, required 1/0/0", jd_cnt, busy_cnt, reads);
        end
    endtask

    task automatic test_protocol_error();
        int e, g;
        begin_job(1, 1'b0);
        for (int i = 0; i < 20 && frame_reads < 3; i++) tick();
        step(1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
        tick();
        n_cmp++;
        if (err !== 1'b1) begin n_bad++; $display("FAIL perr_set: err=%b, required 1", err); end
        run_until_jd(1'b0, 200);
        n_cmp++;
        if (err !== 1'b1 || reads != 8 || jd_cnt != 1) begin
            n_bad++;
            $display("FAIL perr_hold: err=%b reads=%0d jd=%0d, required 1/8/1", err, reads, jd_cnt);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (got_q.size() == 0) begin
                n_bad++; $display("FAIL perr_sb_missing: no frame observed, required %0d reads", e);
            end else begin
                g = got_q.pop_front();
                if (g != e) begin n_bad++; $display("FAIL perr_sb_reads: %0d, required %0d", g, e); end
            end
        end
        tick();
        begin_job(1, 1'b0);
        tick();
        n_cmp++;
        if (err !== 1'b0) begin n_bad++; $display("FAIL perr_clear_on_start: err=%b, required 0", err); end
        run_until_jd(1'b0, 200);
        tick();
    endtask

    task automatic test_abort();
        int e, g;
        begin_job(2, 1'b0);
        for (int i = 0; i < 20 && reads < 5; i++) tick();
        step(1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (bus_if.ff_rdreq !== 1'b0) begin n_bad++; $display("FAIL abort_rdreq_drop: rdreq=%b, required 0", bus_if.ff_rdreq); end
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_idle: busy=%b, required 0", busy); end
        for (int i = 0; i < 5; i++) tick();
        n_cmp++;
        if (fd_cnt != 0 || jd_cnt != 0 || reads != 5 || vd_bad != 0) begin
            n_bad++;
            $display("FAIL abort_quiet: fd=%0d jd=%0d reads=%0d vbad=%0d, required 0/0/5/0", fd_cnt, jd_cnt, reads, vd_bad);
        end
        begin_job(1, 1'b0);
        tick();
        n_cmp++;
        if (frame_idx !== 16'd0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL abort_restart: idx=%0d busy=%b, required 0/1", frame_idx, busy);
        end
        run_until_jd(1'b0, 200);
        n_cmp++;
        if (reads != 8 || jd_cnt != 1) begin
            n_bad++; $display("FAIL abort_restart_reads: reads=%0d jd=%0d, required 8/1", reads, jd_cnt);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (got_q.size() == 0) begin
                n_bad++; $display("FAIL abort_sb_missing: no frame observed, required %0d reads", e);
            end else begin
                g = got_q.pop_front();
                if (g != e) begin n_bad++; $display("FAIL abort_sb_reads: %0d, required %0d", g, e); end
            end
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        begin_job(3, 1'b0);
        step(1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1);   // stray done in STREAM -> err
        for (int i = 0; i < 60 && fd_cnt < 1; i++) tick();
        acc_en = 1'b0;
        acc_delay = 0;
        for (int i = 0; i < 40 && frame_reads < 8; i++) tick();
        tick();
        n_cmp++;
        if (busy !== 1'b1 || frame_idx !== 16'd1 || err !== 1'b1 || bus_if.ff_rdreq !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_precondition: busy=%b idx=%0d err=%b rdreq=%b, required 1/1/1/0",
                     busy, frame_idx, err, bus_if.ff_rdreq);
        end
        step(1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
        tick();
        n_cmp++;
        if ({bus_if.ff_rdreq, bus_if.core_valid_in, busy, frame_done, job_done, err} !== 6'b0
            || frame_idx !== 16'd0) begin
            n_bad++;
            $display("FAIL rst_mid_wait: rdreq=%b valid=%b busy=%b fd=%b jd=%b err=%b idx=%0d, all must be 0",
                     bus_if.ff_rdreq, bus_if.core_valid_in, busy, frame_done, job_done, err, frame_idx);
        end
        step(1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1);   // done while IDLE
        tick();
        n_cmp++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL rst_idle_done_err: err=%b busy=%b, required 1/0", err, busy);
        end
        acc_en = 1'b1;
    endtask

    initial begin
        bus_if.ff_empty  = 1'b0;
        bus_if.ff_full   = 1'b0;
        bus_if.core_done = 1'b0;
        test_reset();
        test_nominal();
        test_backpressure();
        test_zero_frames();
        test_protocol_error();
        test_abort();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
